// File: rtl/io_port_agent.sv
// Device-side IN/OUT port agent: the host fills an input FIFO that the processor reads with IN.
// Words the processor drives with OUT are captured into an output FIFO, which the host drains.
module io_port_agent #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             IOE,
    input  logic             IOR,
    input  logic             IOW,
    output logic [WIDTH-1:0] PORTIN,
    input  logic [WIDTH-1:0] PORTOUT,
    input  logic [WIDTH-1:0] host_in_data,
    input  logic             host_in_valid,
    output logic             host_in_ready,
    output logic [WIDTH-1:0] host_out_data,
    output logic             host_out_valid,
    input  logic             host_out_ready,
    input  logic             clr_err,
    output logic [AW:0]      in_count,
    output logic [AW:0]      out_count,
    output logic             underrun,
    output logic             overrun
);
    localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PONE = AW'(1);

    logic [WIDTH-1:0] in_mem  [DEPTH];
    logic [WIDTH-1:0] out_mem [DEPTH];
    logic [AW-1:0]    in_rd, in_wr, out_rd, out_wr;

    logic rd_ev, wr_ev;
    logic in_pop, in_push, out_pop, out_push;

    assign rd_ev = IOE & IOR;
    assign wr_ev = IOE & IOW;

    assign host_in_ready  = (in_count != FULL);
    assign host_out_valid = (out_count != '0);
    assign PORTIN         = (in_count != '0) ? in_mem[in_rd] : '0;
    assign host_out_data  = out_mem[out_rd];

    assign in_pop   = rd_ev & (in_count != '0);
    assign in_push  = host_in_valid & host_in_ready;
    assign out_pop  = host_out_valid & host_out_ready;
    // A full output FIFO still takes the word when the host frees a slot this cycle
    assign out_push = wr_ev & ((out_count != FULL) | out_pop);

    always_ff @(posedge clk) begin
        if (in_push)
            in_mem[in_wr] <= host_in_data;
        if (out_push)
            out_mem[out_wr] <= PORTOUT;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_rd     <= '0;
            in_wr     <= '0;
            out_rd    <= '0;
            out_wr    <= '0;
            in_count  <= '0;
            out_count <= '0;
            underrun  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (in_pop)
                in_rd <= in_rd + PONE;
            if (in_push)
                in_wr <= in_wr + PONE;
            if (out_pop)
                out_rd <= out_rd + PONE;
            if (out_push)
                out_wr <= out_wr + PONE;

            case ({in_push, in_pop})
                2'b10:   in_count <= in_count + ONE;
                2'b01:   in_count <= in_count - ONE;
                default: in_count <= in_count;
            endcase

            case ({out_push, out_pop})
                2'b10:   out_count <= out_count + ONE;
                2'b01:   out_count <= out_count - ONE;
                default: out_count <= out_count;
            endcase

            // Set beats clear when both land in the same cycle
            if (rd_ev && in_count == '0)
                underrun <= 1'b1;
            else if (clr_err)
                underrun <= 1'b0;

            if (wr_ev && !out_push)
                overrun <= 1'b1;
            else if (clr_err)
                overrun <= 1'b0;
        end
    end
endmodule

// File: tb/tb_io_port_agent.sv
// Bench for io_port_agent: a directed vector table, then random traffic checked against
// a queue-based model, then hand-written async-reset and empty push+IN corner sequences.
module tb_io_port_agent;
    localparam int W = 16;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         IOE = 0, IOR = 0, IOW = 0;
    logic [W-1:0] PORTIN, PORTOUT = '0;
    logic [W-1:0] host_in_data = '0, host_out_data;
    logic         host_in_valid = 0, host_in_ready;
    logic         host_out_valid, host_out_ready = 0;
    logic         clr_err = 0;
    logic [2:0]   in_count, out_count;
    logic         underrun, overrun;

    io_port_agent #(.WIDTH(W), .DEPTH(D), .AW(2)) dut (
        .clk(clk), .reset(reset), .IOE(IOE), .IOR(IOR), .IOW(IOW),
        .PORTIN(PORTIN), .PORTOUT(PORTOUT),
        .host_in_data(host_in_data), .host_in_valid(host_in_valid),
        .host_in_ready(host_in_ready), .host_out_data(host_out_data),
        .host_out_valid(host_out_valid), .host_out_ready(host_out_ready),
        .clr_err(clr_err), .in_count(in_count), .out_count(out_count),
        .underrun(underrun), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] inq[$];
    logic [W-1:0] outq[$];
    bit m_und, m_ovr;

    typedef struct {
        bit rd, wr, clr, hv, hr;
        logic [W-1:0] pout, hin;
        logic [W-1:0] e_pin;
        int e_ic, e_oc;
        logic [W-1:0] e_hod;
        bit e_und, e_ovr;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Queue model: advance one clock using the inputs currently driven
    task automatic model_step();
        bit rd, wr, in_rdy, push_in, pop_out;
        int isz, osz;
        rd = IOE & IOR;
        wr = IOE & IOW;
        isz = inq.size();
        osz = outq.size();
        in_rdy = (isz != D);
        push_in = host_in_valid & in_rdy;
        pop_out = (osz != 0) & host_out_ready;
        if (rd) begin
            if (isz > 0) void'(inq.pop_front());
        end
        if (push_in) inq.push_back(host_in_data);
        if (pop_out) void'(outq.pop_front());
        if (wr) begin
            if (osz < D || pop_out) outq.push_back(PORTOUT);
        end
        if (rd && isz == 0) m_und = 1;
        else if (clr_err) m_und = 0;
        if (wr && !(osz < D || pop_out)) m_ovr = 1;
        else if (clr_err) m_ovr = 0;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".portin"}, PORTIN, inq.size() > 0 ? inq[0] : '0);
        chk({tag, ".in_count"}, in_count, inq.size());
        chk({tag, ".out_count"}, out_count, outq.size());
        chk({tag, ".in_ready"}, host_in_ready, inq.size() != D);
        chk({tag, ".out_valid"}, host_out_valid, outq.size() != 0);
        if (outq.size() > 0)
            chk({tag, ".out_data"}, host_out_data, outq[0]);
        chk({tag, ".underrun"}, underrun, m_und);
        chk({tag, ".overrun"}, overrun, m_ovr);
    endtask

    task automatic drive(input bit ioe, input bit ior, input bit iow,
                         input logic [W-1:0] pout, input bit hv,
                         input logic [W-1:0] hin, input bit hr, input bit clr);
        @(negedge clk);
        IOE = ioe; IOR = ior; IOW = iow; PORTOUT = pout;
        host_in_valid = hv; host_in_data = hin;
        host_out_ready = hr; clr_err = clr;
        model_step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(bit rd, bit wr, bit clr, bit hv, bit hr,
                                logic [W-1:0] pout, logic [W-1:0] hin,
                                logic [W-1:0] e_pin, int e_ic, int e_oc,
                                logic [W-1:0] e_hod, bit e_und, bit e_ovr);
        vec_t v;
        v.rd = rd; v.wr = wr; v.clr = clr; v.hv = hv; v.hr = hr;
        v.pout = pout; v.hin = hin; v.e_pin = e_pin;
        v.e_ic = e_ic; v.e_oc = e_oc; v.e_hod = e_hod;
        v.e_und = e_und; v.e_ovr = e_ovr;
        return v;
    endfunction

    initial begin
        // rd wr clr hv hr  pout     hin      pin      ic oc hod      und ovr
        tbl.push_back(mk(0,0,0,1,0, 16'h0,    16'h1111, 16'h1111, 1,0, 16'h0,    0,0));
        tbl.push_back(mk(0,0,0,1,0, 16'h0,    16'h2222, 16'h1111, 2,0, 16'h0,    0,0));
        tbl.push_back(mk(0,0,0,1,0, 16'h0,    16'h3333, 16'h1111, 3,0, 16'h0,    0,0));
        tbl.push_back(mk(0,0,0,1,0, 16'h0,    16'h4444, 16'h1111, 4,0, 16'h0,    0,0));
        tbl.push_back(mk(1,0,0,0,0, 16'h0,    16'h0,    16'h2222, 3,0, 16'h0,    0,0));
        tbl.push_back(mk(1,0,0,0,0, 16'h0,    16'h0,    16'h3333, 2,0, 16'h0,    0,0));
        tbl.push_back(mk(1,0,0,0,0, 16'h0,    16'h0,    16'h4444, 1,0, 16'h0,    0,0));
        tbl.push_back(mk(1,0,0,0,0, 16'h0,    16'h0,    16'h0,    0,0, 16'h0,    0,0));
        tbl.push_back(mk(1,0,0,0,0, 16'h0,    16'h0,    16'h0,    0,0, 16'h0,    1,0));
        tbl.push_back(mk(1,0,1,0,0, 16'h0,    16'h0,    16'h0,    0,0, 16'h0,    1,0));
        tbl.push_back(mk(0,0,1,0,0, 16'h0,    16'h0,    16'h0,    0,0, 16'h0,    0,0));
        tbl.push_back(mk(0,1,0,0,0, 16'hA001, 16'h0,    16'h0,    0,1, 16'hA001, 0,0));
        tbl.push_back(mk(0,1,0,0,0, 16'hA002, 16'h0,    16'h0,    0,2, 16'hA001, 0,0));
        tbl.push_back(mk(0,1,0,0,0, 16'hA003, 16'h0,    16'h0,    0,3, 16'hA001, 0,0));
        tbl.push_back(mk(0,1,0,0,0, 16'hA004, 16'h0,    16'h0,    0,4, 16'hA001, 0,0));
        tbl.push_back(mk(0,1,0,0,0, 16'hA005, 16'h0,    16'h0,    0,4, 16'hA001, 0,1));
        tbl.push_back(mk(0,0,1,0,0, 16'h0,    16'h0,    16'h0,    0,4, 16'hA001, 0,0));
        tbl.push_back(mk(0,1,0,0,1, 16'hBEEF, 16'h0,    16'h0,    0,4, 16'hA002, 0,0));
        tbl.push_back(mk(0,0,0,0,1, 16'h0,    16'h0,    16'h0,    0,3, 16'hA003, 0,0));
        tbl.push_back(mk(0,0,0,0,1, 16'h0,    16'h0,    16'h0,    0,2, 16'hA004, 0,0));
        tbl.push_back(mk(0,0,0,0,1, 16'h0,    16'h0,    16'h0,    0,1, 16'hBEEF, 0,0));
        tbl.push_back(mk(0,0,0,0,1, 16'h0,    16'h0,    16'h0,    0,0, 16'h0,    0,0));
        tbl.push_back(mk(0,0,0,1,0, 16'h0,    16'h5555, 16'h5555, 1,0, 16'h0,    0,0));
        tbl.push_back(mk(0,0,0,1,0, 16'h0,    16'h6666, 16'h5555, 2,0, 16'h0,    0,0));
        tbl.push_back(mk(1,0,0,1,0, 16'h0,    16'h7777, 16'h6666, 2,0, 16'h0,    0,0));
    end

    initial begin
        // Reset state
        #12;
        chk("rst.in_count", in_count, 0);
        chk("rst.out_count", out_count, 0);
        chk("rst.portin", PORTIN, 0);
        chk("rst.in_ready", host_in_ready, 1);
        chk("rst.out_valid", host_out_valid, 0);
        chk("rst.flags", {underrun, overrun}, 0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            vec_t v;
            v = tbl[i];
            drive(v.rd | v.wr, v.rd, v.wr, v.pout, v.hv, v.hin, v.hr, v.clr);
            chk($sformatf("t%0d.portin", i), PORTIN, v.e_pin);
            chk($sformatf("t%0d.in_count", i), in_count, v.e_ic);
            chk($sformatf("t%0d.out_count", i), out_count, v.e_oc);
            if (v.e_oc != 0)
                chk($sformatf("t%0d.out_data", i), host_out_data, v.e_hod);
            chk($sformatf("t%0d.underrun", i), underrun, v.e_und);
            chk($sformatf("t%0d.overrun", i), overrun, v.e_ovr);
            check_model($sformatf("t%0d.m", i));
        end

        // Random traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            bit ioe;
            ioe = ($urandom_range(0, 3) != 0);
            drive(ioe, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                  W'($urandom), $urandom_range(0, 1) == 1, W'($urandom),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
            check_model($sformatf("r%0d", i));
        end

        // Async reset mid-cycle with both FIFOs partly full
        drive(1, 0, 0, 16'hC0DE, 1, 16'h1234, 0, 1);
        drive(1, 0, 1, 16'hC0DF, 1, 16'h1235, 0, 0);
        @(negedge clk);
        host_in_valid = 0; IOE = 0; IOW = 0; IOR = 0; host_out_ready = 0;
        chk("pre_rst.nonempty", (in_count != 0) && (out_count != 0), 1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst.in_count", in_count, 0);
        chk("arst.out_count", out_count, 0);
        chk("arst.portin", PORTIN, 0);
        chk("arst.out_valid", host_out_valid, 0);
        chk("arst.in_ready", host_in_ready, 1);
        inq.delete();
        outq.delete();
        m_und = 0;
        m_ovr = 0;
        @(negedge clk);
        reset = 1'b1;

        // Push into empty FIFO in the same cycle as an IN
        @(negedge clk);
        IOE = 1; IOR = 1; host_in_valid = 1; host_in_data = 16'h9999;
        #1;
        chk("pushrd.portin_before", PORTIN, 0);
        model_step();
        @(posedge clk);
        #1;
        chk("pushrd.underrun", underrun, 1);
        chk("pushrd.in_count", in_count, 1);
        chk("pushrd.portin_after", PORTIN, 16'h9999);
        check_model("pushrd");

        // OUT latency: valid the cycle after the strobe
        drive(1, 0, 1, 16'h5A5A, 0, 16'h0, 0, 1);
        chk("outlat.valid", host_out_valid, 1);
        chk("outlat.data", host_out_data, 16'h5A5A);
        check_model("outlat");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/io_port_agent.md
Name: io_port_agent

Overview:
Device-side agent for the processor's IN/OUT port. It supplies words on the processor's PORTIN pins from an input FIFO filled by an external host, and advances that FIFO on each processor IN. It also captures each word the processor drives on PORTOUT during an OUT into an output FIFO, which the host drains through a valid/ready handshake. It sits at the chip boundary, watching the same IOE/IOR/IOW strobes the processor's port logic uses.

Parameters:
WIDTH, 16, data width of the port and both FIFOs
DEPTH, 4, entries per FIFO (power of two, >= 2)
AW, 2, log2(DEPTH), pointer width

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  asynchronous, active-low reset
IOE  in  1  processor IO enable strobe
IOR  in  1  processor IO read (IN) strobe
IOW  in  1  processor IO write (OUT) strobe
PORTIN  out  WIDTH  word presented to processor input pins
PORTOUT  in  WIDTH  processor output pins
host_in_data  in  WIDTH  host word to enqueue for the processor
host_in_valid  in  1  host word valid
host_in_ready  out  1  input FIFO can accept
host_out_data  out  WIDTH  oldest captured OUT word
host_out_valid  out  1  output FIFO non-empty
host_out_ready  in  1  host accepts host_out_data
clr_err  in  1  clears sticky error flags
in_count  out  AW+1  input FIFO occupancy, 0..DEPTH
out_count  out  AW+1  output FIFO occupancy, 0..DEPTH
underrun  out  1  sticky: IN issued while input FIFO empty
overrun  out  1  sticky: OUT word dropped, output FIFO full

Behaviour:
- Reset (reset=0, asynchronous): both FIFOs empty, all pointers 0, in_count=out_count=0, underrun=overrun=0. Outputs during and after reset: PORTIN=0, host_out_valid=0, host_in_ready=1. FIFO storage is not cleared. Reset mid-operation discards all queued words.
- rd_ev = IOE & IOR; wr_ev = IOE & IOW. Both are sampled at posedge. Every posedge at which an event is high counts as one event.
- PORTIN is combinational: the input FIFO head when in_count>0, else 0. It is stable for the whole cycle, so the processor's negedge sample sees it.
- Input pop: at a posedge with rd_ev=1 and in_count>0, the read pointer advances (wraps DEPTH-1 -> 0). With in_count=0, no pointer change and underrun is set.
- Input push: host_in_ready = (in_count != DEPTH). When host_in_valid & host_in_ready, the word is written at the write pointer and the pointer advances with wrap.
- Simultaneous input push and pop with in_count in 1..DEPTH-1: both occur and in_count is unchanged.
- Push while empty, same cycle as rd_ev: the push occurs, underrun is set, and PORTIN showed 0 that cycle.
- Push while full is impossible, because ready is low.
- Output capture: at a posedge with wr_ev=1, PORTOUT is written into the output FIFO. The processor updates PORTOUT at the preceding negedge, so the new value is captured.
- Capture when full is allowed only if the host pops in the same cycle (host_out_valid & host_out_ready); otherwise the word is dropped and overrun is set.
- host_out_valid = (out_count != 0). host_out_data is the head (combinational). A pop occurs when valid & ready, and the pointer wraps.
- rd_ev and wr_ev in the same cycle are independent, and both take effect.
- Counts: +1 on push only, -1 on pop only, unchanged on both or neither. Counts never exceed DEPTH or go below 0.
- Sticky flags: set on their event and cleared by clr_err. If a set event and clr_err coincide, set wins.
- Latency: a host word pushed at posedge N appears on PORTIN in cycle N+1 if the FIFO was empty. An OUT at posedge N gives host_out_valid=1 in cycle N+1.

Test Plan:
- Reset, then push 0x1111, 0x2222, 0x3333, 0x4444 -> in_count=4 and host_in_ready=0. Four rd_ev pulses -> PORTIN reads 0x1111..0x4444 in order, then 0, with in_count=0.
- rd_ev with the input FIFO empty -> PORTIN=0, in_count stays 0, underrun=1. clr_err pulsed together with a second rd_ev -> underrun stays 1. A lone clr_err -> underrun=0.
- Five wr_ev with PORTOUT=0xA001..0xA005 and host_out_ready=0 -> out_count=4, overrun=1, and the host then drains 0xA001..0xA004.
- Output FIFO full, wr_ev with PORTOUT=0xBEEF while host_out_ready=1 -> 0xA001 popped, 0xBEEF enqueued, out_count stays 4, overrun not set.
- Input count at 2 with a simultaneous host push and rd_ev -> in_count stays 2. Pointers wrap over 10 mixed operations with no data loss or reordering.
- reset asserted asynchronously mid-cycle with both FIFOs partly full -> immediately in_count=out_count=0, PORTIN=0, host_out_valid=0.
